// File: rtl/perf_event_monitor.sv
// perf_event_monitor: cycle counter plus NUM_CH event counters, run/halt control, registered read port.
// Define PERF_SNAPSHOT_EN to add snap_i and a shadow bank that the read port then reads instead of live counters.
module perf_event_monitor #(
   parameter int              NUM_CH      = 4,
   parameter int              CNT_W       = 32,
   parameter int              SATURATE    = 0,
   parameter longint unsigned CYCLE_LIMIT = 0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              freeze_i,
   input  logic              clear_i,
`ifdef PERF_SNAPSHOT_EN
   input  logic              snap_i,
`endif
   input  logic [NUM_CH-1:0] event_i,
   input  logic [4:0]        rd_sel_i,
   output logic [CNT_W-1:0]  rd_data_o,
   output logic [NUM_CH:0]   ovf_o,
   output logic              running_o,
   output logic              halt_o
);

   // state   | meaning
   // ST_IDLE | stopped, waiting for start_i
   // ST_RUN  | counting on every unfrozen edge
   // ST_HALT | cycle limit reached, only clear/reset leave
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_t;

   localparam int               NCNT      = NUM_CH + 1;
   localparam logic [CNT_W-1:0] ONES      = '1;
   localparam bit               LIMIT_EN  = (CYCLE_LIMIT != 0) && ((CYCLE_LIMIT >> CNT_W) == 0);
   localparam logic [CNT_W-1:0] LIMIT_VAL = CYCLE_LIMIT[CNT_W-1:0];

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q [NCNT];
   logic [CNT_W-1:0] cnt_d [NCNT];
   logic [NUM_CH:0]  ovf_q, ovf_d;
   logic [CNT_W-1:0] rd_data_q, rd_data_d;
   logic             running_q, running_d;
   logic             halt_q, halt_d;
   logic             count_en;
   logic             cyc_hit;
   logic [NUM_CH:0]  ev_ext;
`ifdef PERF_SNAPSHOT_EN
   logic [CNT_W-1:0] shadow_q [NCNT];
   logic [CNT_W-1:0] shadow_d [NCNT];
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      rd_data_d = '0;
      count_en  = (state_q == ST_RUN) && !freeze_i;
      ev_ext    = {1'b1, event_i};
`ifdef PERF_SNAPSHOT_EN
      shadow_d  = shadow_q;
      if (snap_i) shadow_d = cnt_q;
`endif

      // Read path always sees the value from before this edge's update.
      for (int k = 0; k < NCNT; k++) begin
`ifdef PERF_SNAPSHOT_EN
         if (rd_sel_i == 5'(k)) rd_data_d = shadow_q[k];
`else
         if (rd_sel_i == 5'(k)) rd_data_d = cnt_q[k];
`endif
      end

      for (int k = 0; k < NCNT; k++) begin
         if (count_en && ev_ext[k]) begin
            if (cnt_q[k] == ONES) begin
               ovf_d[k] = 1'b1;
               cnt_d[k] = (SATURATE != 0) ? ONES : '0;
            end else begin
               cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
         end
      end

      cyc_hit = LIMIT_EN && count_en && (cnt_d[NUM_CH] == LIMIT_VAL);

      case (state_q)
         ST_IDLE: if (start_i) state_d = ST_RUN;
         ST_RUN: begin
            if (cyc_hit)       state_d = ST_HALT;
            else if (!start_i) state_d = ST_IDLE;
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase

      if (clear_i) begin
         state_d = ST_IDLE;
         cnt_d   = '{default: '0};
         ovf_d   = '0;
`ifdef PERF_SNAPSHOT_EN
         shadow_d = '{default: '0};
`endif
      end

      running_d = (state_d == ST_RUN);
      halt_d    = (state_d == ST_HALT);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '{default: '0};
         ovf_q     <= '0;
         rd_data_q <= '0;
         running_q <= 1'b0;
         halt_q    <= 1'b0;
`ifdef PERF_SNAPSHOT_EN
         shadow_q  <= '{default: '0};
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         rd_data_q <= rd_data_d;
         running_q <= running_d;
         halt_q    <= halt_d;
`ifdef PERF_SNAPSHOT_EN
         shadow_q  <= shadow_d;
`endif
      end
   end

   assign rd_data_o = rd_data_q;
   assign ovf_o     = ovf_q;
   assign running_o = running_q;
   assign halt_o    = halt_q;

endmodule

// File: tb/tb_perf_event_monitor.sv
// Bench for perf_event_monitor: three configurations in lockstep against a behavioural model, plus literal checks.
module tb_perf_event_monitor;

   localparam int NCH = 4;
`ifdef PERF_SNAPSHOT_EN
   localparam bit SNAP = 1'b1;
`else
   localparam bit SNAP = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b0, start = 1'b0, frz = 1'b0, clr = 1'b0, snap = 1'b0;
   logic [3:0] ev = '0;
   logic [4:0] sel = '0;

   logic [7:0]  rd_a, rd_b;
   logic [31:0] rd_c;
   logic [4:0]  ovf_a, ovf_b, ovf_c;
   logic        run_a, run_b, run_c, halt_a, halt_b, halt_c;

   perf_event_monitor #(.NUM_CH(NCH), .CNT_W(8), .SATURATE(0), .CYCLE_LIMIT(0)) dut_a (
      .clk_i(clk), .rst_i(rst), .start_i(start), .freeze_i(frz), .clear_i(clr),
`ifdef PERF_SNAPSHOT_EN
      .snap_i(snap),
`endif
      .event_i(ev), .rd_sel_i(sel), .rd_data_o(rd_a), .ovf_o(ovf_a),
      .running_o(run_a), .halt_o(halt_a));

   perf_event_monitor #(.NUM_CH(NCH), .CNT_W(8), .SATURATE(1), .CYCLE_LIMIT(0)) dut_b (
      .clk_i(clk), .rst_i(rst), .start_i(start), .freeze_i(frz), .clear_i(clr),
`ifdef PERF_SNAPSHOT_EN
      .snap_i(snap),
`endif
      .event_i(ev), .rd_sel_i(sel), .rd_data_o(rd_b), .ovf_o(ovf_b),
      .running_o(run_b), .halt_o(halt_b));

   perf_event_monitor #(.NUM_CH(NCH), .CNT_W(32), .SATURATE(0), .CYCLE_LIMIT(15)) dut_c (
      .clk_i(clk), .rst_i(rst), .start_i(start), .freeze_i(frz), .clear_i(clr),
`ifdef PERF_SNAPSHOT_EN
      .snap_i(snap),
`endif
      .event_i(ev), .rd_sel_i(sel), .rd_data_o(rd_c), .ovf_o(ovf_c),
      .running_o(run_c), .halt_o(halt_c));

   // Model: per instance, counts as plain integers, mode 0=idle 1=run 2=halt.
   int     cw  [3] = '{8, 8, 32};
   int     sat [3] = '{0, 1, 0};
   longint lim [3] = '{0, 0, 15};
   longint m_cnt [3][NCH+1];
   longint m_sh  [3][NCH+1];
   logic [NCH:0] m_ovf [3];
   longint m_rd  [3];
   int     m_st  [3];

   int  n_chk  = 0;
   int  n_pass = 0;
   bit  chk_en = 1'b0;

   task automatic chk(string nm, longint act, longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic model_step();
      for (int i = 0; i < 3; i++) begin
         longint full;
         bit     counted;
         full = longint'(1) << cw[i];
         if (!rst) begin
            for (int k = 0; k <= NCH; k++) begin m_cnt[i][k] = 0; m_sh[i][k] = 0; end
            m_ovf[i] = '0; m_rd[i] = 0; m_st[i] = 0;
         end else begin
            m_rd[i] = 0;
            if (sel <= NCH) m_rd[i] = SNAP ? m_sh[i][sel] : m_cnt[i][sel];
            if (clr) begin
               for (int k = 0; k <= NCH; k++) begin m_cnt[i][k] = 0; m_sh[i][k] = 0; end
               m_ovf[i] = '0; m_st[i] = 0;
            end else begin
               if (SNAP && snap) for (int k = 0; k <= NCH; k++) m_sh[i][k] = m_cnt[i][k];
               counted = (m_st[i] == 1) && !frz;
               if (counted) begin
                  for (int k = 0; k <= NCH; k++) begin
                     if (k == NCH || ev[k]) begin
                        m_cnt[i][k] = m_cnt[i][k] + 1;
                        if (m_cnt[i][k] == full) begin
                           m_ovf[i][k] = 1'b1;
                           m_cnt[i][k] = (sat[i] != 0) ? full - 1 : 0;
                        end
                     end
                  end
               end
               if (m_st[i] == 0) begin
                  if (start) m_st[i] = 1;
               end else if (m_st[i] == 1) begin
                  if (counted && lim[i] != 0 && lim[i] < full && m_cnt[i][NCH] == lim[i]) m_st[i] = 2;
                  else if (!start) m_st[i] = 0;
               end
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("rd_a",   longint'(rd_a),   m_rd[0]);
         chk("rd_b",   longint'(rd_b),   m_rd[1]);
         chk("rd_c",   longint'(rd_c),   m_rd[2]);
         chk("ovf_a",  longint'(ovf_a),  longint'(m_ovf[0]));
         chk("ovf_b",  longint'(ovf_b),  longint'(m_ovf[1]));
         chk("ovf_c",  longint'(ovf_c),  longint'(m_ovf[2]));
         chk("run_a",  longint'(run_a),  longint'(m_st[0] == 1));
         chk("run_b",  longint'(run_b),  longint'(m_st[1] == 1));
         chk("run_c",  longint'(run_c),  longint'(m_st[2] == 1));
         chk("halt_a", longint'(halt_a), longint'(m_st[0] == 2));
         chk("halt_b", longint'(halt_b), longint'(m_st[1] == 2));
         chk("halt_c", longint'(halt_c), longint'(m_st[2] == 2));
      end
   end

   task automatic cyc(bit r, bit s, bit f, bit c, logic [3:0] e, logic [4:0] rs, bit sn);
      @(negedge clk);
      rst = r; start = s; frz = f; clr = c; ev = e; sel = rs; snap = sn;
      @(posedge clk);
      model_step();
   endtask

   // Frozen read; with the shadow bank a snap edge first copies the (frozen) live counters.
   task automatic rd_frozen(bit s, logic [4:0] rs);
      cyc(1, s, 1, 0, 4'h0, rs, SNAP);
      if (SNAP) cyc(1, s, 1, 0, 4'h0, rs, 1'b0);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         for (int k = 0; k <= NCH; k++) begin m_cnt[i][k] = 0; m_sh[i][k] = 0; end
         m_ovf[i] = '0; m_rd[i] = 0; m_st[i] = 0;
      end

      cyc(0, 0, 0, 0, 4'h0, 5'd0, 0);
      cyc(0, 0, 0, 0, 4'h0, 5'd0, 0);
      #1;
      chk("reset_rd",   longint'(rd_c),   0);
      chk("reset_ovf",  longint'(ovf_c),  0);
      chk("reset_run",  longint'(run_c),  0);
      chk("reset_halt", longint'(halt_c), 0);
      chk_en = 1'b1;

      // 10 edges with start high: first enters RUN, 9 count.
      repeat (10) cyc(1, 1, 0, 0, 4'b0001, 5'd0, 0);
      rd_frozen(1, 5'd4); chk("basic_cycles", longint'(rd_c), 9);
      chk("basic_running", longint'(run_c), 1);
      rd_frozen(1, 5'd0); chk("basic_ch0", longint'(rd_a), 9);
      rd_frozen(1, 5'd1); chk("basic_ch1", longint'(rd_c), 0);
      rd_frozen(1, 5'd3); chk("basic_ch3", longint'(rd_b), 0);

      // Read returns the pre-update value on a counting edge.
      cyc(1, 1, 0, 0, 4'b0001, 5'd0, 0); #1;
`ifndef PERF_SNAPSHOT_EN
      chk("rd_preupdate", longint'(rd_c), 9);
`endif
      rd_frozen(1, 5'd0); chk("rd_after", longint'(rd_c), 10);
      rd_frozen(1, 5'd20); chk("rd_sel_oob", longint'(rd_c), 0);

      // Cycle limit on dut_c.
      cyc(1, 0, 0, 1, 4'h0, 5'd0, 0); #1;
      chk("clr_halt", longint'(halt_c), 0);
      chk("clr_run",  longint'(run_c),  0);
      chk("clr_ovf",  longint'(ovf_c),  0);
      cyc(1, 1, 0, 0, 4'h0, 5'd0, 0);
      for (int j = 0; j < 15; j++) begin
         cyc(1, 1, 0, 0, (j % 2 == 0) ? 4'b0010 : 4'b0000, 5'd0, 0); #1;
         if (j == 13) chk("halt_before_limit", longint'(halt_c), 0);
         if (j == 14) begin
            chk("halt_at_limit", longint'(halt_c), 1);
            chk("run_at_limit",  longint'(run_c),  0);
         end
      end
      repeat (5) cyc(1, 1, 0, 0, 4'($urandom), 5'd4, 0);
      rd_frozen(1, 5'd4); chk("halt_cycles", longint'(rd_c), 15);
      rd_frozen(1, 5'd1); chk("halt_ch1", longint'(rd_c), 8);
      chk("halt_held",   longint'(halt_c), 1);
      chk("halt_no_run", longint'(run_c),  0);

      // 257 counting edges of ch2 on 8-bit counters.
      cyc(1, 0, 0, 1, 4'h0, 5'd0, 0);
      cyc(1, 1, 0, 0, 4'h0, 5'd0, 0);
      repeat (257) cyc(1, 1, 0, 0, 4'b0100, 5'd0, 0);
      rd_frozen(1, 5'd2);
      chk("wrap_ch2", longint'(rd_a), 1);
      chk("sat_ch2",  longint'(rd_b), 255);
      chk("lim_ch2",  longint'(rd_c), 15);
      chk("wrap_ovf", longint'(ovf_a), longint'(5'b10100));
      chk("sat_ovf",  longint'(ovf_b), longint'(5'b10100));
      chk("lim_ovf",  longint'(ovf_c), 0);
      rd_frozen(1, 5'd4);
      chk("wrap_cycles", longint'(rd_a), 1);
      chk("sat_cycles",  longint'(rd_b), 255);

      // Freeze on 3 of 10 RUN edges.
      cyc(1, 0, 0, 1, 4'h0, 5'd0, 0);
      cyc(1, 1, 0, 0, 4'h0, 5'd0, 0);
      for (int j = 0; j < 10; j++) cyc(1, 1, (j == 2 || j == 5 || j == 8), 0, 4'b1111, 5'd0, 0);
      for (int k = 0; k <= NCH; k++) begin
         rd_frozen(1, 5'(k));
         chk("frz_a", longint'(rd_a), 7);
         chk("frz_c", longint'(rd_c), 7);
      end
      cyc(1, 1, 1, 1, 4'hf, 5'd0, 0); #1;
      chk("frzclr_ovf",  longint'(ovf_a),  0);
      chk("frzclr_run",  longint'(run_a),  0);
      chk("frzclr_halt", longint'(halt_c), 0);
      rd_frozen(0, 5'd4); chk("frzclr_cycles", longint'(rd_a), 0);

`ifdef PERF_SNAPSHOT_EN
      cyc(1, 0, 0, 1, 4'h0, 5'd0, 0);
      cyc(1, 1, 0, 0, 4'h0, 5'd0, 0);
      repeat (12) cyc(1, 1, 0, 0, 4'b0001, 5'd0, 0);
      cyc(1, 1, 0, 0, 4'b0001, 5'd0, 1);
      repeat (3) cyc(1, 1, 0, 0, 4'b0001, 5'd0, 0);
      cyc(1, 1, 1, 0, 4'h0, 5'd0, 0); #1;
      chk("snap_hold", longint'(rd_a), 12);
      cyc(1, 1, 0, 1, 4'h0, 5'd0, 1);
      cyc(1, 1, 1, 0, 4'h0, 5'd0, 0); #1;
      chk("snap_clr", longint'(rd_a), 0);
`endif

      // Random phase.
      for (int n = 0; n < 4000; n++) begin
         cyc(($urandom_range(0, 999) != 0),
             ($urandom_range(0, 9) != 0),
             ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 199) == 0),
             4'($urandom),
             ($urandom_range(0, 9) == 0) ? 5'd20 : 5'($urandom_range(0, 5)),
             SNAP && ($urandom_range(0, 7) == 0));
      end

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
